bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_bus_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master (instruction m0 / data m1) to single-slave bus arbiter with a 3-state IDLE/BUSY/DONE FSM.
// Define ARB_ROUND_ROBIN_EN for round-robin contention resolution; the default is fixed priority (m1 wins).
module bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_breq,
  input  logic              m0_bstart,
  input  logic              m0_ttype,
  input  logic [1:0]        m0_tsize,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_bdone,
  input  logic              m1_breq,
  input  logic              m1_bstart,
  input  logic              m1_ttype,
  input  logic [1:0]        m1_tsize,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_bdone,
  output logic              s_breq,
  output logic              s_bstart,
  output logic              s_ttype,
  output logic [1:0]        s_tsize,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_bdone,
  output logic [1:0]        gnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic              owner_q;
  logic [1:0]        gnt_q;
  logic              s_breq_q;
  logic              s_bstart_q;
  logic              ttype_q;
  logic [1:0]        tsize_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;
  logic              m0_bdone_q;
  logic              m1_bdone_q;

  logic req0;
  logic req1;
  logic owner_d;

  assign req0 = m0_breq & m0_bstart;
  assign req1 = m1_breq & m1_bstart;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;
  // Under contention the master that did not hold the previous grant wins.
  assign owner_d = req1 & (~req0 | ~last_q);
`else
  assign owner_d = req1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      gnt_q      <= 2'b00;
      s_breq_q   <= 1'b0;
      s_bstart_q <= 1'b0;
      ttype_q    <= 1'b0;
      tsize_q    <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_bdone_q <= 1'b0;
      m1_bdone_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          m0_bdone_q <= 1'b0;
          m1_bdone_q <= 1'b0;
          if (req0 | req1) begin
            state_q    <= BUSY;
            owner_q    <= owner_d;
            gnt_q      <= owner_d ? 2'b10 : 2'b01;
            s_breq_q   <= 1'b1;
            s_bstart_q <= 1'b1;
            ttype_q    <= owner_d ? m1_ttype : m0_ttype;
            tsize_q    <= owner_d ? m1_tsize : m0_tsize;
            addr_q     <= owner_d ? m1_addr  : m0_addr;
            wdata_q    <= owner_d ? m1_wdata : m0_wdata;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= owner_d;
`endif
          end
        end
        BUSY: begin
          // Master inputs are deliberately not looked at here; only the slave can end the transfer.
          s_bstart_q <= 1'b0;
          if (s_bdone) begin
            state_q  <= DONE;
            s_breq_q <= 1'b0;
            if (owner_q) begin
              m1_rdata_q <= s_rdata;
              m1_bdone_q <= 1'b1;
            end else begin
              m0_rdata_q <= s_rdata;
              m0_bdone_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q    <= IDLE;
          gnt_q      <= 2'b00;
          m0_bdone_q <= 1'b0;
          m1_bdone_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign s_breq   = s_breq_q;
  assign s_bstart = s_bstart_q;
  assign s_ttype  = ttype_q;
  assign s_tsize  = tsize_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign m0_bdone = m0_bdone_q;
  assign m1_bdone = m1_bdone_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed, table-driven bench for bus_arbiter plus hand-written corner sequences.
// Contention expectations follow ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_breq = 0, m0_bstart = 0, m0_ttype = 0;
  logic [1:0]  m0_tsize = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0;
  logic [31:0] m0_rdata;
  logic        m0_bdone;
  logic        m1_breq = 0, m1_bstart = 0, m1_ttype = 0;
  logic [1:0]  m1_tsize = 0;
  logic [31:0] m1_addr = 0, m1_wdata = 0;
  logic [31:0] m1_rdata;
  logic        m1_bdone;
  logic        s_breq, s_bstart, s_ttype;
  logic [1:0]  s_tsize;
  logic [31:0] s_addr, s_wdata;
  logic [31:0] s_rdata = 0;
  logic        s_bdone = 0;
  logic [1:0]  gnt;

  int total = 0;
  int bad = 0;
  logic [31:0] m0_rd_exp = 0;
  logic [31:0] m1_rd_exp = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_breq(m0_breq), .m0_bstart(m0_bstart), .m0_ttype(m0_ttype), .m0_tsize(m0_tsize),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_bdone(m0_bdone),
    .m1_breq(m1_breq), .m1_bstart(m1_bstart), .m1_ttype(m1_ttype), .m1_tsize(m1_tsize),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_bdone(m1_bdone),
    .s_breq(s_breq), .s_bstart(s_bstart), .s_ttype(s_ttype), .s_tsize(s_tsize),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_bdone(s_bdone),
    .gnt(gnt)
  );

  typedef struct {
    bit          r0;
    bit          r1;
    bit          tt0;
    bit [1:0]    ts0;
    logic [31:0] a0;
    logic [31:0] w0;
    bit          tt1;
    bit [1:0]    ts1;
    logic [31:0] a1;
    logic [31:0] w1;
    int          dly;
    logic [31:0] rd;
    bit          exp1;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_masters();
    m0_breq = 0; m0_bstart = 0;
    m1_breq = 0; m1_bstart = 0;
  endtask

  // Request issued in the current IDLE cycle; returns at the following IDLE cycle.
  task automatic run_vec(input vec_t v, input string nm);
    logic [1:0]  eg;
    logic [31:0] ea, ew;
    eg = v.exp1 ? 2'b10 : 2'b01;
    ea = v.exp1 ? v.a1 : v.a0;
    ew = v.exp1 ? v.w1 : v.w0;
    m0_breq = v.r0; m0_bstart = v.r0; m0_ttype = v.tt0; m0_tsize = v.ts0;
    m0_addr = v.a0; m0_wdata = v.w0;
    m1_breq = v.r1; m1_bstart = v.r1; m1_ttype = v.tt1; m1_tsize = v.ts1;
    m1_addr = v.a1; m1_wdata = v.w1;
    tick();
    chk({nm, ".gnt"}, 32'(gnt), 32'(eg));
    chk({nm, ".s_bstart"}, 32'(s_bstart), 32'd1);
    chk({nm, ".s_breq"}, 32'(s_breq), 32'd1);
    chk({nm, ".s_addr"}, s_addr, ea);
    chk({nm, ".s_wdata"}, s_wdata, ew);
    chk({nm, ".s_ttype"}, 32'(s_ttype), 32'(v.exp1 ? v.tt1 : v.tt0));
    chk({nm, ".s_tsize"}, 32'(s_tsize), 32'(v.exp1 ? v.ts1 : v.ts0));
    drop_masters();
    for (int i = 0; i < v.dly; i++) begin
      tick();
      chk({nm, ".bstart_low"}, 32'(s_bstart), 32'd0);
      chk({nm, ".breq_held"}, 32'(s_breq), 32'd1);
      chk({nm, ".addr_held"}, s_addr, ea);
    end
    s_bdone = 1; s_rdata = v.rd;
    tick();
    s_bdone = 0; s_rdata = 32'h0;
    if (v.exp1) m1_rd_exp = v.rd; else m0_rd_exp = v.rd;
    chk({nm, ".m0_bdone"}, 32'(m0_bdone), 32'(!v.exp1));
    chk({nm, ".m1_bdone"}, 32'(m1_bdone), 32'(v.exp1));
    chk({nm, ".m0_rdata"}, m0_rdata, m0_rd_exp);
    chk({nm, ".m1_rdata"}, m1_rdata, m1_rd_exp);
    chk({nm, ".done_gnt"}, 32'(gnt), 32'(eg));
    chk({nm, ".done_breq"}, 32'(s_breq), 32'd0);
    tick();
    chk({nm, ".idle_gnt"}, 32'(gnt), 32'd0);
    chk({nm, ".idle_bdone"}, 32'({m1_bdone, m0_bdone}), 32'd0);
    $display("xfer %s owner=m%0d addr=%h rdata=%h", nm, v.exp1, ea, v.rd);
  endtask

  vec_t tbl [6];

  initial begin
    // Contention rows: fixed mode always m1; RR alternates starting after an m0 grant.
    tbl[0] = '{1, 0, 0, 2'b10, 32'h0000_0100, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 32'h0000_0013, 0};
    tbl[1] = '{1, 1, 0, 2'b10, 32'h0000_0010, 32'h1111_0000, 1, 2'b01, 32'h0000_0020, 32'h2222_0000, 0, 32'h0000_00A1, 1};
    tbl[2] = '{1, 1, 1, 2'b00, 32'h0000_0030, 32'h3333_0000, 0, 2'b10, 32'h0000_0040, 32'h4444_0000, 2, 32'h0000_00A2, RR ? 1'b0 : 1'b1};
    tbl[3] = '{1, 1, 0, 2'b01, 32'h0000_0050, 32'h5555_0000, 1, 2'b00, 32'h0000_0060, 32'h6666_0000, 0, 32'h0000_00A3, 1};
    tbl[4] = '{0, 1, 0, 2'b00, 32'h0, 32'h0, 1, 2'b10, 32'h2000_0004, 32'hDEAD_BEEF, 0, 32'h0000_0000, 1};
    tbl[5] = '{1, 0, 1, 2'b01, 32'h0000_0070, 32'h0000_BEEF, 0, 2'b00, 32'h0, 32'h0, 3, 32'h0000_0055, 0};

    #2;
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.s_breq", 32'(s_breq), 32'd0);
    chk("rst.bdone", 32'({m1_bdone, m0_bdone}), 32'd0);
    chk("rst.rdata", m0_rdata | m1_rdata, 32'd0);
    tick();
    tick();
    rst_n = 1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // m1 write with m0 arriving and m1 changing fields mid-BUSY.
    m1_breq = 1; m1_bstart = 1; m1_ttype = 1; m1_tsize = 2'b10;
    m1_addr = 32'h2000_0004; m1_wdata = 32'hDEAD_BEEF;
    tick();
    chk("mid.gnt", 32'(gnt), 32'b10);
    m0_breq = 1; m0_bstart = 1; m0_ttype = 0; m0_tsize = 2'b10; m0_addr = 32'h0000_0300;
    m1_breq = 0; m1_bstart = 0; m1_addr = 32'h0; m1_wdata = 32'h0;
    tick();
    chk("mid.s_addr", s_addr, 32'h2000_0004);
    chk("mid.s_wdata", s_wdata, 32'hDEAD_BEEF);
    chk("mid.gnt_held", 32'(gnt), 32'b10);
    s_bdone = 1; s_rdata = 32'h77;
    tick();
    s_bdone = 0;
    m1_rd_exp = 32'h77;
    chk("mid.m1_bdone", 32'(m1_bdone), 32'd1);
    chk("mid.m0_bdone", 32'(m0_bdone), 32'd0);
    chk("mid.m1_rdata", m1_rdata, 32'h77);
    tick();
    chk("mid.idle_gnt", 32'(gnt), 32'd0);
    chk("mid.idle_breq", 32'(s_breq), 32'd0);
    tick();
    chk("mid.m0_gnt", 32'(gnt), 32'b01);
    chk("mid.m0_addr", s_addr, 32'h0000_0300);
    chk("mid.m0_bstart", 32'(s_bstart), 32'd1);
    drop_masters();
    s_bdone = 1; s_rdata = 32'h88;
    tick();
    s_bdone = 0;
    m0_rd_exp = 32'h88;
    chk("mid.m0_done", 32'(m0_bdone), 32'd1);
    chk("mid.m0_rdata", m0_rdata, 32'h88);
    chk("mid.m1_rdata_hold", m1_rdata, 32'h77);
    tick();
    $display("xfer mid_busy m1 write then m0 read served after idle");

    // Reset pulse in the middle of an m0 transfer.
    m0_breq = 1; m0_bstart = 1; m0_ttype = 0; m0_addr = 32'h0000_0400;
    tick();
    chk("abort.gnt", 32'(gnt), 32'b01);
    drop_masters();
    #2 rst_n = 0;
    #1;
    chk("abort.gnt0", 32'(gnt), 32'd0);
    chk("abort.s_breq", 32'({s_breq, s_bstart}), 32'd0);
    chk("abort.s_addr", s_addr, 32'd0);
    chk("abort.rdata", m0_rdata | m1_rdata, 32'd0);
    m0_rd_exp = 0; m1_rd_exp = 0;
    @(posedge clk);
    #1 rst_n = 1;
    s_bdone = 1; s_rdata = 32'h99;
    tick();
    chk("abort.no_bdone", 32'({m1_bdone, m0_bdone}), 32'd0);
    s_bdone = 0;
    tick();
    chk("abort.no_bdone2", 32'({m1_bdone, m0_bdone}), 32'd0);
    chk("abort.idle", 32'(gnt), 32'd0);
    $display("xfer abort by reset, no completion");
    run_vec('{1, 1, 0, 2'b10, 32'h0000_0500, 32'h0, 0, 2'b10, 32'h0000_0600, 32'h0, 1, 32'h0000_00B1, RR ? 1'b0 : 1'b1}, "post_rst_a");
    run_vec('{1, 1, 0, 2'b10, 32'h0000_0510, 32'h0, 0, 2'b10, 32'h0000_0610, 32'h0, 0, 32'h0000_00B2, 1}, "post_rst_b");

    // Stray slave completion while idle, then m1 drops breq mid-BUSY.
    s_bdone = 1; s_rdata = 32'hBAD0_0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stray.bdone", 32'({m1_bdone, m0_bdone}), 32'd0);
      chk("stray.gnt", 32'(gnt), 32'd0);
      chk("stray.rdata", m0_rdata | m1_rdata, 32'h0000_00B2 & {32{1'b1}} & m1_rd_exp);
    end
    s_bdone = 0;
    $display("xfer stray s_bdone ignored");
    run_vec('{0, 1, 0, 2'b00, 32'h0, 32'h0, 0, 2'b01, 32'h0000_0700, 32'h0, 2, 32'h0000_00C1, 1}, "m1_drop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
